ahb_instr_sequencer: RTL
========================

// Module: ahb_instr_sequencer
// PURPOSE
//  Synthesisable replacement for the file-based AMBA stimulus driver. Stores a programmed list of
//  AHB instructions and issues them to the AHB master over the amba_en/instr_rd handshake,
//  optionally replaying the list several times. Captures slave write-backs into a result FIFO.
//  Sits between the test controller (load/start) and the AHB master of the FIR subsystem.
// PARAMETERS
//  DWIDTH  32  data width of instruction payload and slave write data
//  AWIDTH  32  address width
//  DEPTH   16  instruction memory entries (power of 2, >=2)
//  RDEPTH  8   result FIFO entries (power of 2, >=2)
//  IWIDTH  DWIDTH+AWIDTH+6  instruction word {HWRITE,HSIZE[2:0],HTRANS[1:0],addr,data}
// PORTS
//  clk            in   1                 single clock, all logic on rising edge
//  rst            in   1                 synchronous reset, active-high
//  load_valid     in   1                 instruction word offered for programming
//  load_ready     out  1                 sequencer accepts load_instr this cycle
//  load_instr     in   IWIDTH            instruction word to append
//  clear          in   1                 IDLE only: empty program, flush result FIFO, clear overflow
//  start          in   1                 IDLE only: begin issuing the program
//  abort          in   1                 RUN only: stop issuing, return to IDLE
//  loop_cnt       in   8                 extra passes; sampled at start (total passes = loop_cnt+1)
//  amba_instr     out  IWIDTH            current instruction to AHB master
//  amba_en        out  1                 amba_instr valid
//  instr_rd       in   1                 master consumed amba_instr (ignored while amba_en=0)
//  amba_wr_flg    in   1                 slave write-back valid
//  amba_slv_addr  in   AWIDTH            write-back address
//  amba_slv_data  in   DWIDTH            write-back data
//  res_valid      out  1                 result FIFO non-empty
//  res_ready      in   1                 pop result FIFO
//  res_addr       out  AWIDTH            head-of-FIFO address
//  res_data       out  DWIDTH            head-of-FIFO data
//  res_overflow   out  1                 sticky: a write-back was dropped (FIFO full)
//  busy           out  1                 state is RUN
//  done           out  1                 one-cycle pulse at program completion
//  issued_cnt     out  16                instructions consumed since last start, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, prog_len=0, rd_ptr=0, result FIFO empty; all outputs 0 except load_ready=1.
//  FSM states IDLE, RUN, DONE.
//  IDLE: load_ready = (prog_len<DEPTH). load_valid&&load_ready -> mem[prog_len]=load_instr,
//    prog_len++. Full: load_ready=0, further loads ignored. clear has priority over start and load.
//    start with prog_len>0 -> RUN next cycle; rd_ptr=0, loops_left=loop_cnt, issued_cnt=0.
//    start with prog_len==0 -> DONE (no issue).
//  RUN: amba_en=1, amba_instr=mem[rd_ptr] (combinational from register array, valid same cycle as
//    amba_en). load_ready=0; load, start, clear ignored. On instr_rd: issued_cnt++ (saturating);
//    if rd_ptr==prog_len-1: loops_left==0 -> DONE, else rd_ptr=0, loops_left--; otherwise rd_ptr++.
//    abort -> IDLE next cycle, amba_en=0 that cycle; abort together with instr_rd: the read is
//    counted, no further issue. Program memory is retained after abort and done.
//  DONE: one cycle, done=1, amba_en=0; then IDLE. Restarting replays the same program.
//  Result FIFO: push {addr,data} on amba_wr_flg in any state; pop on res_valid&&res_ready.
//    Push+pop same cycle when full: both happen, count unchanged. Push when full, no pop:
//    entry dropped, res_overflow=1 until clear or rst. Pointers wrap modulo RDEPTH.
//  Reset mid-RUN: immediate return to reset values; program contents undefined (prog_len=0).
// CONFIGURATION
//  AHB_SEQ_FILTER_EN defined: write-backs with amba_slv_data[DWIDTH-1]==1 are not pushed and
//    never set res_overflow. Undefined: every amba_wr_flg write-back is pushed.
// TESTING
//  Load 3 instrs, loop_cnt=0, start, instr_rd every cycle -> amba_instr = I0,I1,I2; done 1 cycle
//    after last rd; issued_cnt=3.
//  Load 2 instrs, loop_cnt=2, instr_rd random gaps -> sequence I0,I1 x3; issued_cnt=6; done once.
//  Load DEPTH+1 words -> load_ready=0 after 16th; 17th ignored; replay shows 16 words only.
//  RDEPTH+1 write-backs with res_ready=0 -> res_valid=1, 8 entries in order, res_overflow=1;
//    then push+pop same cycle when full -> count stays 8, no new overflow.
//  abort after 1 of 4 instrs -> amba_en=0 next cycle, busy=0, no done; restart replays from I0.
//  AHB_SEQ_FILTER_EN: write-backs data 32'h8000_0001 and 32'h0000_0005 -> only 5 popped.

Source files
------------

// File: rtl/ahb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ahb_instr_sequencer
// Brief    : Replays a programmed AHB instruction list to the AHB master and
//            collects slave write-backs in a result FIFO. Build option
//            AHB_SEQ_FILTER_EN drops write-backs whose data MSB is set.
// Revision : 1.0
// ============================================================================
module ahb_instr_sequencer #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int RDEPTH = 8,
  parameter int IWIDTH = DWIDTH + AWIDTH + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [IWIDTH-1:0] load_instr,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        loop_cnt,
  output logic [IWIDTH-1:0] amba_instr,
  output logic              amba_en,
  input  logic              instr_rd,
  input  logic              amba_wr_flg,
  input  logic [AWIDTH-1:0] amba_slv_addr,
  input  logic [DWIDTH-1:0] amba_slv_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [AWIDTH-1:0] res_addr,
  output logic [DWIDTH-1:0] res_data,
  output logic              res_overflow,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(RDEPTH);
  localparam int EW = AWIDTH + DWIDTH;
  localparam logic [PW:0] C_DEPTH  = (PW+1)'(DEPTH);
  localparam logic [RW:0] C_RDEPTH = (RW+1)'(RDEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW:0]       prog_len_q, prog_len_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]        loops_left_q, loops_left_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;
  logic [IWIDTH-1:0] mem_q [DEPTH];

  logic [EW-1:0]     fifo_q [RDEPTH];
  logic [RW-1:0]     wptr_q, wptr_d;
  logic [RW-1:0]     rptr_q, rptr_d;
  logic [RW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              load_ok;
  logic              last_entry;
  logic              fifo_flush;
  logic              push_req;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_push;

  assign load_ready = (state_q == S_IDLE) && !clear && (prog_len_q != C_DEPTH);
  assign load_ok    = load_valid && load_ready;
  assign last_entry = ({1'b0, rd_ptr_q} == (prog_len_q - 1'b1));
  assign fifo_flush = (state_q == S_IDLE) && clear;

  // Sequencer control: program append in IDLE, list replay in RUN.
  always_comb begin
    state_d      = state_q;
    prog_len_d   = prog_len_q;
    rd_ptr_d     = rd_ptr_q;
    loops_left_d = loops_left_q;
    issued_cnt_d = issued_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          prog_len_d = '0;
        end else begin
          if (load_ok) begin
            prog_len_d = prog_len_q + 1'b1;
          end
          if (start) begin
            rd_ptr_d     = '0;
            loops_left_d = loop_cnt;
            issued_cnt_d = '0;
            state_d      = (prog_len_q != '0) ? S_RUN : S_DONE;
          end
        end
      end
      S_RUN: begin
        if (instr_rd) begin
          if (issued_cnt_q != 16'hFFFF) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
          end
          if (last_entry) begin
            if (loops_left_q == 8'd0) begin
              state_d = S_DONE;
            end else begin
              rd_ptr_d     = '0;
              loops_left_d = loops_left_q - 8'd1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
        // A read accepted in the abort cycle still counts, but nothing more is issued.
        if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef AHB_SEQ_FILTER_EN
  assign push_req = amba_wr_flg && !amba_slv_data[DWIDTH-1];
`else
  assign push_req = amba_wr_flg;
`endif

  assign fifo_full = (count_q == C_RDEPTH);
  assign fifo_pop  = (count_q != '0) && res_ready;
  assign fifo_push = push_req && (!fifo_full || fifo_pop) && !fifo_flush;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (fifo_flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (fifo_push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push_req && fifo_full && !fifo_pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prog_len_q   <= '0;
      rd_ptr_q     <= '0;
      loops_left_q <= '0;
      issued_cnt_q <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      rd_ptr_q     <= rd_ptr_d;
      loops_left_q <= loops_left_d;
      issued_cnt_q <= issued_cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by prog_len_q and count_q.
  always_ff @(posedge clk) begin
    if (!rst && load_ok && !clear) begin
      mem_q[prog_len_q[PW-1:0]] <= load_instr;
    end
    if (!rst && fifo_push) begin
      fifo_q[wptr_q] <= {amba_slv_addr, amba_slv_data};
    end
  end

  assign amba_en      = (state_q == S_RUN);
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign amba_instr   = amba_en ? mem_q[rd_ptr_q] : '0;
  assign issued_cnt   = issued_cnt_q;
  assign res_valid    = (count_q != '0);
  assign res_addr     = res_valid ? fifo_q[rptr_q][EW-1:DWIDTH] : '0;
  assign res_data     = res_valid ? fifo_q[rptr_q][DWIDTH-1:0] : '0;
  assign res_overflow = overflow_q;

endmodule
`default_nettype wire
